// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART blocks (transmitter now, receiver
//   later).
//   DATA_BITS               : bits per character
//   BAUD_CW                 : width of the baud down-counter
//   DEFAULT_CLOCKS_PER_BAUD : 12 MHz system clock / 9600 baud
//   uart_state_e            : frame sequencing states
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BAUD_CW   = 24;

  localparam logic [BAUD_CW-1:0] DEFAULT_CLOCKS_PER_BAUD = 24'd1250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter
//   Loadable baud-period down-counter. A load takes priority over counting.
//   Otherwise the counter decrements every cycle until it reaches zero, and
//   it rests at zero until the next load.
//   i_clk    : system clock
//   i_reset  : synchronous, active-high reset (count -> 0)
//   i_load   : load i_reload on this edge
//   i_reload : value loaded, normally CLOCKS_PER_BAUD-1
//   o_count  : current count
//   o_zero   : count is zero, marking the last cycle of a bit period
module uart_baud_counter
  import uart_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [BAUD_CW-1:0] i_reload,
  output logic [BAUD_CW-1:0] o_count,
  output logic               o_zero
);

  logic [BAUD_CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_reload;
    end else if (count_q != '0) begin
      count_d = count_q - BAUD_CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_zero  = (count_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Byte-wide UART transmitter. It sends 8N1 frames by default. When the
//   macro UART_TX_PARITY_EN is defined, it sends 8E1 or 8O1 frames (parity
//   sense set by PARITY_ODD).
//   A request is accepted when i_wr && !o_busy. Back-to-back frames run with
//   no idle gap.
//   i_clk     : system clock
//   i_reset   : synchronous, active-high reset; abandons any frame
//   i_wr      : transmit request
//   i_data    : byte to send, sampled on the accept cycle only
//   o_uart_tx : serial line, idle high (registered)
//   o_busy    : frame in progress (registered); low in the final stop cycle
//
// state  | meaning
// IDLE   | line high, waiting for a request
// START  | start bit (0)
// DATA   | data bits, LSB first; idx_q counts 0..7
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (1); a request in its last cycle chains the next frame
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter logic [BAUD_CW-1:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
  parameter logic               PARITY_ODD      = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_uart_tx,
  output logic                 o_busy
);

  localparam logic [BAUD_CW-1:0] RELOAD = CLOCKS_PER_BAUD - BAUD_CW'(1);

  // The busy flag drops one cycle before the stop bit ends, so the count
  // must pass through 1.
  if (CLOCKS_PER_BAUD < BAUD_CW'(2)) begin : g_bad_baud
    $error("uart_tx_serializer: CLOCKS_PER_BAUD must be >= 2");
  end

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 load;
  logic                 zero;
  logic                 accept;
  logic [BAUD_CW-1:0]   count;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  uart_baud_counter u_baud (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (load),
    .i_reload (RELOAD),
    .o_count  (count),
    .o_zero   (zero)
  );

  // A request can only be taken while idle or in the final stop cycle.
  // Those are exactly the cycles in which busy_q is low.
  assign accept = i_wr && !busy_q &&
                  ((state_q == IDLE) || ((state_q == STOP) && zero));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d = START;
          load    = 1'b1;
          shift_d = i_data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = (^i_data) ^ PARITY_ODD;
`endif
        end
      end

      START: begin
        if (zero) begin
          state_d = DATA;
          load    = 1'b1;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
        end
      end

      DATA: begin
        if (zero) begin
          load = 1'b1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (zero) begin
          state_d = STOP;
          load    = 1'b1;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        // Clear busy on the edge entering the last stop cycle, so a
        // request can be taken in that cycle without a gap.
        if (count == BAUD_CW'(1)) begin
          busy_d = 1'b0;
        end
        if (zero) begin
          if (accept) begin
            state_d = START;
            load    = 1'b1;
            shift_d = i_data;
            idx_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d = (^i_data) ^ PARITY_ODD;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= 8'hFF;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Stimulus pushes the expected byte (and the required start-to-start gap,
//   or 0 when it does not apply) into a queue. The line monitor decodes each
//   frame and compares it against the queue.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk;
  logic       i_reset;
  logic       i_wr;
  logic [7:0] i_data;
  logic       o_uart_tx;
  logic       o_busy;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frames_seen = 0;

  uart_tx_serializer #(.CLOCKS_PER_BAUD(24'd4), .PARITY_ODD(1'b0)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
    .o_uart_tx(o_uart_tx), .o_busy(o_busy)
  );

`ifdef UART_TX_PARITY_EN
  logic tx_odd, busy_odd;
  uart_tx_serializer #(.CLOCKS_PER_BAUD(24'd4), .PARITY_ODD(1'b1)) dut_odd (
    .i_clk(clk), .i_reset(i_reset), .i_wr(i_wr), .i_data(i_data),
    .o_uart_tx(tx_odd), .o_busy(busy_odd)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Inputs change 2 time units after the rising edge. The monitor samples
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  logic          mon_active = 1'b0;
  int            mon_pos;
  int            mon_start;
  int            mon_prev_start = 0;
  int            mon_last_end = 0;
  logic [NB-1:0] mon_bits;
  logic          mon_cur;
  logic          mon_stable;
  logic          mon_busy_ok;

  initial forever begin
    @(negedge clk);
    if (i_reset) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active) begin
        if (o_uart_tx === 1'b0) begin
          mon_active  = 1'b1;
          mon_pos     = 0;
          mon_start   = cyc;
          mon_bits    = '0;
          mon_stable  = 1'b1;
          mon_busy_ok = 1'b1;
        end
      end else begin
        mon_pos++;
      end
      if (mon_active) begin
        if ((mon_pos % CPB) == 0) mon_cur = o_uart_tx;
        else if (o_uart_tx !== mon_cur) mon_stable = 1'b0;
        mon_bits[mon_pos / CPB] = o_uart_tx;
        if (o_busy !== ((mon_pos != FRAME - 1) ? 1'b1 : 1'b0)) mon_busy_ok = 1'b0;
        if (mon_pos == FRAME - 1) begin
          exp_t e;
          mon_active = 1'b0;
          frames_seen++;
          mon_last_end = cyc;
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_data", 32'(mon_bits[8:1]), 32'(e.data));
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 32'(mon_bits[9]), 32'(^e.data));
`endif
            check("frame_stop", 32'(mon_bits[NB-1]), 32'd1);
            check("bit_stable", 32'(mon_stable), 32'd1);
            check("busy_profile", 32'(mon_busy_ok), 32'd1);
            if (e.gap > 0) check("frame_gap", 32'(mon_start - mon_prev_start), 32'(e.gap));
          end
          mon_prev_start = mon_start;
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 20 * FRAME) begin
      step();
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  string msg;
  logic  idle_ok;
  int    first_acc;
  int    frames_before;
  int    n;

  initial begin
    i_reset = 1'b1;
    i_wr    = 1'b0;
    i_data  = 8'h00;
    msg     = "Hello, World! \n\r";

    // 1: reset for 3 cycles, then 100 idle cycles
    step();
    check("reset_tx", 32'(o_uart_tx), 32'd1);
    check("reset_busy", 32'(o_busy), 32'd0);
    step();
    step();
    i_reset = 1'b0;
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_100", 32'(idle_ok), 32'd1);

    // 2: single 'H' (8'h48): 0 | 0,0,0,1,0,0,1,0 | 1
    i_data = 8'h48;
    i_wr   = 1'b1;
    exp_q.push_back('{data: 8'h48, gap: 0});
    step();
    i_wr = 1'b0;
    check("latency_tx", 32'(o_uart_tx), 32'd0);
    check("latency_busy", 32'(o_busy), 32'd1);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < 37; i++) step();
    check("parity_even_bit", 32'(o_uart_tx), 32'd0);
    check("parity_odd_bit", 32'(tx_odd), 32'd1);
    for (int i = 0; i < 6; i++) step();
    check("odd_busy_last_stop", 32'(busy_odd), 32'd0);
    step();
    check("odd_idle_after", 32'(tx_odd), 32'd1);
`endif
    drain();

    // 3: request held high through 16 bytes, back-to-back
    for (int i = 0; i < 10; i++) step();
    frames_before = frames_seen;
    first_acc = 0;
    i_wr = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_data = msg[k];
      n = 0;
      while (o_busy !== 1'b0 && n < 2 * FRAME) begin
        step();
        n++;
      end
      check("wait_busy_low", 32'(o_busy), 32'd0);
      exp_q.push_back('{data: msg[k], gap: (k == 0) ? 0 : FRAME});
      if (k == 0) first_acc = cyc + 1;
      step();
    end
    i_wr = 1'b0;
    drain();
    check("burst_frames", 32'(frames_seen - frames_before), 32'd16);
    check("burst_end", 32'(mon_last_end + 1 - first_acc), 32'(16 * FRAME));

    // 4: request during busy is ignored
    for (int i = 0; i < 10; i++) step();
    frames_before = frames_seen;
    i_data = 8'h55;
    i_wr   = 1'b1;
    exp_q.push_back('{data: 8'h55, gap: 0});
    step();
    i_wr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    i_data = 8'hAA;
    i_wr   = 1'b1;
    step();
    i_wr = 1'b0;
    drain();
    for (int i = 0; i < 2 * FRAME; i++) step();
    check("busy_ignore_frames", 32'(frames_seen - frames_before), 32'd1);
    check("busy_ignore_idle", 32'({o_uart_tx, o_busy}), 32'b10);

    // 5: reset mid-frame, then a clean frame
    i_data = 8'hFF;
    i_wr   = 1'b1;
    step();
    i_wr = 1'b0;
    for (int i = 0; i < 14; i++) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("abort_tx", 32'(o_uart_tx), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0) idle_ok = 1'b0;
    end
    check("abort_no_tail", 32'(idle_ok), 32'd1);
    frames_before = frames_seen;
    i_data = 8'h01;
    i_wr   = 1'b1;
    exp_q.push_back('{data: 8'h01, gap: 0});
    step();
    i_wr = 1'b0;
    drain();
    check("after_reset_frames", 32'(frames_seen - frames_before), 32'd1);

    for (int i = 0; i < 5; i++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
